mai_kick_addr_gen: RTL



---
 rtl/mai_kick_addr_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mai_kick_addr_gen.sv
// Sprite ROM address generator and kick-animation sequencer for the mai_kick renderer.
// Frame changes are confined to frame_start so the displayed sprite never tears mid-frame.
module mai_kick_addr_gen #(
  parameter int unsigned FRAME_W    = 80,
  parameter int unsigned FRAME_H    = 96,
  parameter int unsigned NUM_FRAMES = 6,
  parameter int unsigned HOLD       = 4
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        kick_req,
  input  logic [9:0]  draw_x,
  input  logic [9:0]  draw_y,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        facing_left,
  output logic [15:0] rom_address,
  output logic        in_sprite,
  output logic        kick_busy,
  output logic [2:0]  frame_idx
);

  localparam int unsigned HoldW     = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [15:0] FrameSize = 16'(FRAME_W * FRAME_H);
  localparam logic [2:0]  LastFrame = 3'(NUM_FRAMES - 1);
  localparam logic [HoldW-1:0] LastHold = HoldW'(HOLD - 1);

  typedef enum logic [1:0] {StIdle, StActive, StCooldown} state_e;

  state_e           state_q, state_d;
  logic [2:0]       frame_idx_q, frame_idx_d;
  logic [15:0]      frame_base_q, frame_base_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             pending_q, pending_d;
  logic             kick_busy_q;
  logic [15:0]      rom_address_q, rom_address_d;
  logic             in_sprite_q, in_sprite_d;

  logic [10:0] x_end, y_end;
  logic        in_box;
  logic [9:0]  dx, dy, col;

  // Animation sequencer; frame_base tracks frame_idx incrementally instead of multiplying.
  always_comb begin
    state_d      = state_q;
    frame_idx_d  = frame_idx_q;
    frame_base_d = frame_base_q;
    hold_cnt_d   = hold_cnt_q;
    pending_d    = pending_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start && (pending_q || kick_req)) begin
          state_d      = StActive;
          frame_idx_d  = 3'd1;
          frame_base_d = FrameSize;
          hold_cnt_d   = '0;
          pending_d    = 1'b0;
        end else if (kick_req) begin
          pending_d = 1'b1;
        end
      end
      StActive: begin
        if (frame_start) begin
          if (hold_cnt_q < LastHold) begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end else if (frame_idx_q < LastFrame) begin
            frame_idx_d  = frame_idx_q + 3'd1;
            frame_base_d = frame_base_q + FrameSize;
            hold_cnt_d   = '0;
          end else begin
            state_d      = StCooldown;
            frame_idx_d  = '0;
            frame_base_d = '0;
          end
        end
      end
      StCooldown: begin
        if (frame_start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bounds are widened to 11 bits so a sprite near the right/bottom edge cannot wrap to 0.
  always_comb begin
    x_end  = {1'b0, pos_x} + 11'(FRAME_W);
    y_end  = {1'b0, pos_y} + 11'(FRAME_H);
    in_box = (draw_x >= pos_x) && ({1'b0, draw_x} < x_end) &&
             (draw_y >= pos_y) && ({1'b0, draw_y} < y_end);
    dx     = draw_x - pos_x;
    dy     = draw_y - pos_y;
    col    = facing_left ? (10'(FRAME_W - 1) - dx) : dx;
    rom_address_d = '0;
    in_sprite_d   = 1'b0;
    if (in_box) begin
      rom_address_d = frame_base_q + 16'(32'(dy) * FRAME_W) + {6'd0, col};
      in_sprite_d   = 1'b1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      frame_idx_q   <= '0;
      frame_base_q  <= '0;
      hold_cnt_q    <= '0;
      pending_q     <= 1'b0;
      kick_busy_q   <= 1'b0;
      rom_address_q <= '0;
      in_sprite_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_idx_q   <= frame_idx_d;
      frame_base_q  <= frame_base_d;
      hold_cnt_q    <= hold_cnt_d;
      pending_q     <= pending_d;
      kick_busy_q   <= (state_d != StIdle);
      rom_address_q <= rom_address_d;
      in_sprite_q   <= in_sprite_d;
    end
  end

  assign rom_address = rom_address_q;
  assign in_sprite   = in_sprite_q;
  assign kick_busy   = kick_busy_q;
  assign frame_idx   = frame_idx_q;

endmodule
